// File: rtl/csa_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial carry-select adder controller:
// FSM state encoding and the width of the time-shared adder slice.
package csa_serial_add_ctrl_pkg;

    // Width of the shared adder slice in bits.
    localparam int NIB = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for an index that must count 0..count-1, never below 1 bit.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/csa_serial_add_ctrl_csa4_slice.sv
// Purely combinational 4-bit carry-select adder slice. Two ripple adders
// precompute the sum for carry-in 0 and 1; the real carry-in picks one.
// The carry into bit 3 is exported so the caller can derive signed overflow.
module csa4_slice
    import csa_serial_add_ctrl_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           cin,
    output logic [NIB-1:0] s,
    output logic           cout,
    output logic           c3
);

    logic [NIB:0]   carry0;
    logic [NIB:0]   carry1;
    logic [NIB-1:0] sum0;
    logic [NIB-1:0] sum1;

    // Ripple adder assuming carry-in 0.
    always_comb begin
        carry0[0] = 1'b0;
        for (int i = 0; i < NIB; i++) begin
            sum0[i]     = a[i] ^ b[i] ^ carry0[i];
            carry0[i+1] = (a[i] & b[i]) | (a[i] & carry0[i]) | (b[i] & carry0[i]);
        end
    end

    // Ripple adder assuming carry-in 1.
    always_comb begin
        carry1[0] = 1'b1;
        for (int i = 0; i < NIB; i++) begin
            sum1[i]     = a[i] ^ b[i] ^ carry1[i];
            carry1[i+1] = (a[i] & b[i]) | (a[i] & carry1[i]) | (b[i] & carry1[i]);
        end
    end

    // Carry-select muxes: the late-arriving carry-in only drives select lines.
    always_comb begin
        s    = cin ? sum1 : sum0;
        cout = cin ? carry1[NIB] : carry0[NIB];
        c3   = cin ? carry1[NIB-1] : carry0[NIB-1];
    end

endmodule

// File: rtl/csa_serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit carry-select slice,
// least-significant nibble first, with the carry chained through a flop.
// Valid/ready on both operand and result sides; the result is held in DONE
// until the consumer takes it.
module csa_serial_add_ctrl
    import csa_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             busy
);

    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             c_q;
    logic             ovf_q;
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic             last_nib;
    logic [NIB-1:0]   nib_a;
    logic [NIB-1:0]   nib_b;
    logic [NIB-1:0]   slice_s;
    logic             slice_cout;
    logic             slice_c3;

    // Select the current nibble of each operand for the shared slice.
    always_comb begin
        nib_a = a_q[NIB*int'(idx) +: NIB];
        nib_b = b_q[NIB*int'(idx) +: NIB];
    end

    csa4_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    // State register; reset has priority over any request on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_nib   = (idx == LAST_IDX);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on the accept edge; later operand changes are ignored.
    always_ff @(posedge clk) begin
        // NOTE: operand flops carry no reset; they are always loaded on accept
        // before anything reads them.
        if (accept && !rst) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Nibble sequencing: accumulate sum, chain carry, latch flags on the last pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            s_q     <= '0;
            carry_q <= cin;
            idx     <= '0;
        end else if (state == RUN) begin
            s_q[NIB*int'(idx) +: NIB] <= slice_s;
            carry_q                   <= slice_cout;
            if (last_nib) begin
                // Signed overflow: carry into the MSB differs from carry out.
                c_q   <= slice_cout;
                ovf_q <= slice_c3 ^ slice_cout;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign s   = s_q;
    assign c   = c_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_csa_serial_add_ctrl.sv
// Self-checking bench for csa_serial_add_ctrl (WIDTH=16). The stimulus side
// pushes hand-computed results into a scoreboard on each accept; a monitor
// pops and compares on every result handshake.
module tb_csa_serial_add_ctrl;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c;
    logic        ovf;
    logic        busy;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    csa_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c         (c),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every completed result handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", 32'(s), 32'(e.s));
                check("carry", 32'(c), 32'(e.c));
                check("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Wait for in_ready, present operands, and complete the accept edge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         input logic push, input logic [15:0] es, input logic ec,
                         input logic eo);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'(1));
        a        = av;
        b        = bv;
        cin      = ci;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) sb.push_back('{es, ec, eo});
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
    endtask

    // Count edges from accept until out_valid and check the latency.
    task automatic wait_result();
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(4));
    endtask

    // Let the handshake edge pass and confirm the return to IDLE.
    task automatic finish_handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", 32'(out_valid), 32'(0));
        check("in_ready_back", 32'(in_ready), 32'(1));
    endtask

    task automatic add(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       input logic [15:0] es, input logic ec, input logic eo);
        issue(av, bv, ci, 1'b1, es, ec, eo);
        wait_result();
        finish_handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_s", 32'(s), 32'(0));
        check("rst_c", 32'(c), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));

        // Directed arithmetic vectors.
        add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        add(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Backpressure: result held for 3 cycles, concurrent request ignored.
        out_ready = 1'b0;
        issue(16'h00F0, 16'h0F10, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        wait_result();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111;
            b        = 16'h2222;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'(1));
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_s", 32'(s), 32'(16'h1000));
            check("bp_c", 32'(c), 32'(0));
            check("bp_ovf", 32'(ovf), 32'(0));
        end
        in_valid = 1'b0;
        finish_handshake();
        check("bp_no_accept", 32'(busy), 32'(0));

        // Reset on the second RUN cycle discards the operation.
        issue(16'h1111, 16'h1111, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'(1));
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_s", 32'(s), 32'(0));
        check("mid_rst_c", 32'(c), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_result", 32'(out_valid), 32'(0));

        // Reset together with in_valid: no accept.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h0003;
        b        = 16'h0004;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_valid_busy", 32'(busy), 32'(0));

        // Fresh request after reset with normal latency.
        add(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/csa_serial_add_ctrl.md
Name: csa_serial_add_ctrl

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit addition by time-sharing one 4-bit carry-select adder slice, one nibble per clock, least-significant nibble first.
- The carry is chained between nibbles through a registered carry flop.
- Valid/ready handshake on both the operand side and the result side.
- Sits between a requesting datapath and the shared 4-bit carry-select slice; the wide result and flags are held until the consumer accepts them.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived number of slice passes. Not overridden by the instantiator.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A, sampled on the accept edge.
- b  input  WIDTH  operand B, sampled on the accept edge.
- cin  input  1  carry-in to nibble 0, sampled on the accept edge.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum.
- c  output  1  carry-out of the most-significant nibble.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN and DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, s 0, c 0, ovf 0, nibble index 0, carry flop 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register a, b, cin into the operand/carry flops, clear the nibble index and the sum register, go to RUN.
  - RUN: in_ready=0. Each edge drives nibble k of A/B plus the carry flop into the slice, writes the slice sum into s[4k+3:4k], loads the slice carry into the carry flop, and increments k. On the edge processing k=NIBBLES-1: latch c, compute ovf from that nibble's bit-3 internal carry, go to DONE.
  - DONE: out_valid=1. s, c and ovf are held stable while out_ready=0. On out_ready=1, go to IDLE and drop out_valid. A new request is not accepted in that same edge; in_ready rises the following cycle.
- Latency:
  - out_valid rises NIBBLES edges after the accepting edge (4 for WIDTH=16, 1 for WIDTH=4).
  - Throughput is one addition per NIBBLES+2 cycles.
- in_valid during RUN or DONE is ignored; the requester must hold it until in_ready.
- Operand changes after acceptance have no effect.
- Arithmetic:
  - Modulo 2^WIDTH.
  - {c,s} = a + b + cin exactly.
  - Nibble index counter width is clog2(NIBBLES) bits, minimum 1; it never wraps within an operation.
- Reset mid-operation (RUN or DONE): the next cycle is the reset state; the partial sum is discarded and no out_valid pulse appears.
- rst together with in_valid: reset wins; no accept.
- out_ready outside DONE: ignored.
- s is updated only during RUN. It shows partial results while busy and is defined only when out_valid=1.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - slice width constant NIB=4.
- Sub-module csa4_slice: purely combinational 4-bit carry-select slice.
  - Two 4-bit ripple adders with carry-in 0 and 1.
  - 2:1 muxes on sum and carry, selected by the carry-in.
  - Exposes the bit-3 carry-in for ovf.
- The controller instantiates exactly one csa4_slice.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid exactly 4 edges after accept; s=0x5555, c=0, ovf=0; in_ready returns 1 one cycle after the result handshake.
- a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, c=1, ovf=0 (full carry ripple through all 4 nibble passes).
- a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, c=0, ovf=1. Then a=0x8000, b=0x8000 -> s=0x0000, c=1, ovf=1.
- a=0x0000, b=0x0000, cin=1 -> s=0x0001, c=0.
- Backpressure: a=0x00F0, b=0x0F10, out_ready=0 for 3 cycles after out_valid -> s=0x1000, c, ovf and out_valid held stable. in_ready=0 and a concurrent in_valid is not accepted. Release out_ready -> state returns to IDLE.
- Reset: assert rst on the second RUN cycle -> next cycle in_ready=1, out_valid=0, s=0, c=0. A fresh request a=0x0001, b=0x0001 then yields s=0x0002 with normal latency.
